// File: rtl/rvcpu_pkg.sv
// rvcpu: shared core types and constants.
//   Width         - architectural address width
//   pc_t          - program counter type
//   inst_t        - 32-bit instruction word
//   InstBytes     - PC increment per sequential fetch
//   fetch_state_t - fetch sequencer states
package rvcpu;

    localparam int unsigned Width = 32;

    typedef logic [Width-1:0] pc_t;
    typedef logic [31:0]      inst_t;

    localparam pc_t InstBytes = pc_t'(4);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: 32-bit wrapping event counter.
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, clears the count
//   en_i    - count one event this cycle
//   count_o - current count
module perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the PC, issues one
// instruction-memory request at a time, presents each fetched instruction
// to decode over valid/ready, and applies branch-unit redirects, discarding
// any in-flight fetch made stale by a redirect.
//   clk, rst         - clock, asynchronous active-high reset
//   imem_req_*       - request port (valid/ready, addr = PC)
//   imem_rsp_*       - response for the single outstanding request
//   inst_*           - instruction + PC to decode (valid/ready)
//   redirect(_pc)    - taken branch/jump target from execute
// Optional build macro FETCH_PERF_EN adds perf_redirects / perf_dropped
// event counters (32-bit, wrapping).
module fetch_ctrl
    import rvcpu::*;
#(
    parameter pc_t ResetPc = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [Width-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_data,
    output logic [Width-1:0] inst_pc,
    input  logic             redirect,
    input  logic [Width-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_redirects,
    output logic [31:0]      perf_dropped
`endif
);

    fetch_state_t state_q;
    pc_t          pc_q;
    pc_t          inst_pc_q;
    inst_t        inst_data_q;
    logic         req_valid_q;
    logic         hold_q;

    // Targets are word aligned; the low two bits are ignored.
    pc_t  target;
    logic unused_redirect_lsbs;
    assign target               = {redirect_pc[Width-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= ResetPc;
            inst_pc_q   <= '0;
            inst_data_q <= '0;
            req_valid_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                end
                REQ: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    // An accepted request is stale if redirected in the same cycle.
                    if (imem_req_ready) begin
                        state_q     <= redirect ? DRAIN : WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid && !redirect) begin
                        inst_data_q <= imem_rsp_data;
                        inst_pc_q   <= pc_q;
                        pc_q        <= pc_q + InstBytes;
                        state_q     <= HOLD;
                        hold_q      <= 1'b1;
                    end else if (imem_rsp_valid) begin
                        pc_q        <= target;
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end else if (redirect) begin
                        pc_q    <= target;
                        state_q <= DRAIN;
                    end
                end
                HOLD: begin
                    // Redirect wins over inst_ready: the handshake never completes.
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (redirect || inst_ready) begin
                        state_q     <= REQ;
                        hold_q      <= 1'b0;
                        req_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_rsp_valid) begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BOOT;
                    req_valid_q <= 1'b0;
                    hold_q      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = hold_q & ~redirect;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;

`ifdef FETCH_PERF_EN
    logic drop_evt;
    assign drop_evt = (state_q == WAIT  && imem_rsp_valid && redirect) ||
                      (state_q == DRAIN && imem_rsp_valid) ||
                      (state_q == HOLD  && redirect);

    perf_counter u_perf_redirects (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (redirect),
        .count_o (perf_redirects)
    );

    perf_counter u_perf_dropped (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (drop_evt),
        .count_o (perf_dropped)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_dropped;
`endif

    fetch_ctrl #(.ResetPc(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_data;
        logic        irdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_data;
        logic [31:0] exp_ipc;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs[NVEC];
    int   applied;
    int   miscompares;

    function automatic vec_t mk(logic ready, logic rsp_v, logic [31:0] rsp_data,
                                logic irdy, logic redir, logic [31:0] rpc,
                                logic exp_rv, logic [31:0] exp_addr, logic exp_iv,
                                logic [31:0] exp_data, logic [31:0] exp_ipc);
        vec_t v;
        v.ready = ready; v.rsp_v = rsp_v; v.rsp_data = rsp_data;
        v.irdy = irdy; v.redir = redir; v.rpc = rpc;
        v.exp_rv = exp_rv; v.exp_addr = exp_addr; v.exp_iv = exp_iv;
        v.exp_data = exp_data; v.exp_ipc = exp_ipc;
        return v;
    endfunction

    task automatic check_outs(input string name, input logic rv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] data, input logic [31:0] ipc);
        applied++;
        if (imem_req_valid !== rv || imem_req_addr !== addr || inst_valid !== iv ||
            inst_data !== data || inst_pc !== ipc) begin
            miscompares++;
            $display("FAIL %s: got rv=%b addr=%h iv=%b data=%h pc=%h, want rv=%b addr=%h iv=%b data=%h pc=%h",
                     name, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
                     rv, addr, iv, data, ipc);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic check_perf(input string name, input logic [31:0] er, input logic [31:0] ed);
        applied++;
        if (perf_redirects !== er || perf_dropped !== ed) begin
            miscompares++;
            $display("FAIL %s: got redirects=%0d dropped=%0d, want redirects=%0d dropped=%0d",
                     name, perf_redirects, perf_dropped, er, ed);
        end
    endtask
`endif

    initial begin
        applied     = 0;
        miscompares = 0;

        //                ready rsp data          irdy redir rpc           | rv addr          iv data          ipc
        // Sequential fetch from 0x100: REQ/WAIT/HOLD, 3 cycles per instruction.
        vecs[0]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 1, 32'hA000_0000, 1, 0, 32'h0,         0, 32'h100,       0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h104,       1, 32'hA000_0000, 32'h100);
        vecs[4]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h104,       0, 32'hA000_0000, 32'h100);
        vecs[5]  = mk(0, 1, 32'hA000_0001, 1, 0, 32'h0,         0, 32'h104,       0, 32'hA000_0000, 32'h100);
        vecs[6]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h108,       1, 32'hA000_0001, 32'h104);
        vecs[7]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h108,       0, 32'hA000_0001, 32'h104);
        vecs[8]  = mk(0, 1, 32'hA000_0002, 1, 0, 32'h0,         0, 32'h108,       0, 32'hA000_0001, 32'h104);
        vecs[9]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10C,       1, 32'hA000_0002, 32'h108);
        // Redirect in WAIT before the response: DRAIN, stale response dropped.
        vecs[10] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10C,       0, 32'hA000_0002, 32'h108);
        vecs[11] = mk(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'h10C,       0, 32'hA000_0002, 32'h108);
        vecs[12] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h200,       0, 32'hA000_0002, 32'h108);
        vecs[13] = mk(0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0,         0, 32'h200,       0, 32'hA000_0002, 32'h108);
        vecs[14] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       0, 32'hA000_0002, 32'h108);
        // Redirect to unaligned 0x303 together with the response.
        vecs[15] = mk(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h303,       0, 32'h200,       0, 32'hA000_0002, 32'h108);
        vecs[16] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h300,       0, 32'hA000_0002, 32'h108);
        // Redirect while the request is stalled: address changes under valid.
        vecs[17] = mk(0, 0, 32'h0,         1, 1, 32'h400,       1, 32'h300,       0, 32'hA000_0002, 32'h108);
        vecs[18] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h400,       0, 32'hA000_0002, 32'h108);
        vecs[19] = mk(0, 1, 32'hC000_0004, 1, 0, 32'h0,         0, 32'h400,       0, 32'hA000_0002, 32'h108);
        // Decode stalls 5 cycles in HOLD.
        for (int i = 20; i < 25; i++)
            vecs[i] = mk(0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h404,       1, 32'hC000_0004, 32'h400);
        // Redirect beats inst_ready; then fetch at the top of the address space wraps.
        vecs[25] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h404,       0, 32'hC000_0004, 32'h400);
        vecs[26] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'hC000_0004, 32'h400);
        vecs[27] = mk(0, 1, 32'hE000_0000, 1, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'hC000_0004, 32'h400);
        vecs[28] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hE000_0000, 32'hFFFF_FFFC);
        vecs[29] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, 32'hE000_0000, 32'hFFFF_FFFC);
        // Enter DRAIN for the reset-in-DRAIN sequence below.
        vecs[30] = mk(0, 0, 32'h0,         1, 1, 32'h500,       0, 32'h0,         0, 32'hE000_0000, 32'hFFFF_FFFC);
        vecs[31] = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h500,       0, 32'hE000_0000, 32'hFFFF_FFFC);

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;

        #3;
        check_outs("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
        check_perf("perf_reset", 32'd0, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            imem_req_ready = vecs[i].ready;
            imem_rsp_valid = vecs[i].rsp_v;
            imem_rsp_data  = vecs[i].rsp_data;
            inst_ready     = vecs[i].irdy;
            redirect       = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr,
                       vecs[i].exp_iv, vecs[i].exp_data, vecs[i].exp_ipc);
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        check_perf("perf_totals", 32'd5, 32'd3);
`endif

        // Reset mid-DRAIN: asynchronous clear, then a late response must be ignored.
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        rst            = 1'b1;
        #1;
        check_outs("reset_in_drain", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
        check_perf("perf_cleared", 32'd0, 32'd0);
`endif
        @(negedge clk);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1A7E_0000;
        #1;
        check_outs("boot_late_rsp", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        check_outs("first_req_after_reset", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check_outs("req_held_after_late_rsp", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1;
        check_outs("wait_after_accept", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
